// File: rtl/ibuf_shuffle_stream.sv
// ibuf_shuffle_stream
// Registered, streaming IBUF bank shuffler. Beats arrive on a valid/ready
// input, are transformed according to the burst's latched mode
// (bypass / shuffle / unshuffle), tagged with a last flag from burst framing,
// and queued in a 2-entry skid buffer that drives the output registers.
module ibuf_shuffle_stream #(
  parameter int DDR_BANDWIDTH = 512,
  parameter int NUM_BANKS     = 8,
  parameter int DATA_WIDTH    = 8,
  parameter int BURST_W       = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [1:0]               cfg_mode,
  input  logic [BURST_W-1:0]       cfg_burst_len,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [DDR_BANDWIDTH-1:0] s_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [DDR_BANDWIDTH-1:0] m_data,
  output logic                     m_last,
  output logic                     burst_done,
  output logic                     busy
);

  localparam int DW    = DATA_WIDTH;
  localparam int RATIO = DDR_BANDWIDTH / (NUM_BANKS * DATA_WIDTH);

  // A beat must split evenly into NUM_BANKS x RATIO elements.
  if ((DDR_BANDWIDTH % (NUM_BANKS * DATA_WIDTH)) != 0) begin : g_bad_params
    $error("ibuf_shuffle_stream: DDR_BANDWIDTH must be a multiple of NUM_BANKS*DATA_WIDTH");
  end

  typedef enum logic {ST_IDLE = 1'b0, ST_BURST = 1'b1} state_t;

  // Interleaved -> bank-contiguous: element (i*NUM_BANKS+j) lands at (j*RATIO+i).
  function automatic logic [DDR_BANDWIDTH-1:0] shuffle_beat(input logic [DDR_BANDWIDTH-1:0] x);
    logic [DDR_BANDWIDTH-1:0] y;
    y = {DDR_BANDWIDTH{1'b0}};
    for (int i = 0; i < RATIO; i++) begin
      for (int j = 0; j < NUM_BANKS; j++) begin
        y[(j*RATIO+i)*DW +: DW] = x[(i*NUM_BANKS+j)*DW +: DW];
      end
    end
    return y;
  endfunction

  // Bank-contiguous -> interleaved; exact inverse of shuffle_beat.
  function automatic logic [DDR_BANDWIDTH-1:0] unshuffle_beat(input logic [DDR_BANDWIDTH-1:0] x);
    logic [DDR_BANDWIDTH-1:0] y;
    y = {DDR_BANDWIDTH{1'b0}};
    for (int i = 0; i < RATIO; i++) begin
      for (int j = 0; j < NUM_BANKS; j++) begin
        y[(i*NUM_BANKS+j)*DW +: DW] = x[(j*RATIO+i)*DW +: DW];
      end
    end
    return y;
  endfunction

  // Mode 3 is reserved and behaves as bypass.
  function automatic logic [DDR_BANDWIDTH-1:0] transform_beat(input logic [1:0] mode,
                                                              input logic [DDR_BANDWIDTH-1:0] x);
    logic [DDR_BANDWIDTH-1:0] y;
    case (mode)
      2'd1:    y = shuffle_beat(x);
      2'd2:    y = unshuffle_beat(x);
      default: y = x;
    endcase
    return y;
  endfunction

  state_t                     state_q, state_d;
  logic [BURST_W-1:0]         count_q, count_d;
  logic [BURST_W-1:0]         len_q, len_d;
  logic [1:0]                 mode_q, mode_d;

  logic                       head_valid_q, head_valid_d;
  logic                       head_last_q, head_last_d;
  logic [DDR_BANDWIDTH-1:0]   head_data_q, head_data_d;
  logic                       skid_valid_q, skid_valid_d;
  logic                       skid_last_q, skid_last_d;
  logic [DDR_BANDWIDTH-1:0]   skid_data_q, skid_data_d;
  logic                       s_ready_q, s_ready_d;
  logic                       burst_done_q, burst_done_d;
  logic                       busy_q, busy_d;

  logic                       push_s;
  logic                       pop_s;
  logic [1:0]                 eff_mode_s;
  logic                       beat_last_s;
  logic [DDR_BANDWIDTH-1:0]   push_data_s;

  assign push_s = s_valid & s_ready_q;
  assign pop_s  = head_valid_q & m_ready;

  // Burst framing: pick the beat's mode, decide its last flag, advance count/state.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    len_d       = len_q;
    mode_d      = mode_q;
    eff_mode_s  = mode_q;
    beat_last_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        eff_mode_s  = cfg_mode;
        beat_last_s = (cfg_burst_len == {BURST_W{1'b0}});
        if (push_s) begin
          mode_d = cfg_mode;
          len_d  = cfg_burst_len;
          if (beat_last_s) begin
            count_d = {BURST_W{1'b0}};
          end else begin
            state_d = ST_BURST;
            count_d = BURST_W'(1);
          end
        end else begin
          count_d = count_q;
        end
      end
      ST_BURST: begin
        eff_mode_s  = mode_q;
        beat_last_s = (count_q == len_q);
        if (push_s) begin
          if (beat_last_s) begin
            state_d = ST_IDLE;
            count_d = {BURST_W{1'b0}};
          end else begin
            count_d = count_q + BURST_W'(1);
          end
        end else begin
          count_d = count_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        count_d = {BURST_W{1'b0}};
      end
    endcase
  end

  assign push_data_s = transform_beat(eff_mode_s, s_data);

  // Two-entry buffer (head drives the outputs, skid catches one beat of overrun).
  always_comb begin
    head_valid_d = head_valid_q;
    head_last_d  = head_last_q;
    head_data_d  = head_data_q;
    skid_valid_d = skid_valid_q;
    skid_last_d  = skid_last_q;
    skid_data_d  = skid_data_q;
    case ({head_valid_q, skid_valid_q})
      2'b00: begin
        if (push_s) begin
          head_valid_d = 1'b1;
          head_last_d  = beat_last_s;
          head_data_d  = push_data_s;
        end else begin
          head_valid_d = 1'b0;
        end
      end
      2'b10: begin
        if (push_s && pop_s) begin
          head_last_d = beat_last_s;
          head_data_d = push_data_s;
        end else if (push_s) begin
          skid_valid_d = 1'b1;
          skid_last_d  = beat_last_s;
          skid_data_d  = push_data_s;
        end else if (pop_s) begin
          head_valid_d = 1'b0;
          head_last_d  = 1'b0;
        end else begin
          head_valid_d = 1'b1;
        end
      end
      2'b11: begin
        if (pop_s) begin
          head_last_d  = skid_last_q;
          head_data_d  = skid_data_q;
          skid_valid_d = 1'b0;
          skid_last_d  = 1'b0;
        end else begin
          skid_valid_d = 1'b1;
        end
      end
      default: begin
        // Unreachable (skid without head); promote the skid entry.
        head_valid_d = skid_valid_q;
        head_last_d  = skid_last_q;
        head_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
        skid_last_d  = 1'b0;
      end
    endcase
  end

  // Registered status outputs derived from next-state values.
  always_comb begin
    s_ready_d    = ~skid_valid_d;
    burst_done_d = pop_s & head_last_q;
    busy_d       = (state_d == ST_BURST) | head_valid_d;
  end

  // State, framing and buffer registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      count_q      <= {BURST_W{1'b0}};
      len_q        <= {BURST_W{1'b0}};
      mode_q       <= 2'd0;
      head_valid_q <= 1'b0;
      head_last_q  <= 1'b0;
      head_data_q  <= {DDR_BANDWIDTH{1'b0}};
      skid_valid_q <= 1'b0;
      skid_last_q  <= 1'b0;
      skid_data_q  <= {DDR_BANDWIDTH{1'b0}};
      s_ready_q    <= 1'b1;
      burst_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      len_q        <= len_d;
      mode_q       <= mode_d;
      head_valid_q <= head_valid_d;
      head_last_q  <= head_last_d;
      head_data_q  <= head_data_d;
      skid_valid_q <= skid_valid_d;
      skid_last_q  <= skid_last_d;
      skid_data_q  <= skid_data_d;
      s_ready_q    <= s_ready_d;
      burst_done_q <= burst_done_d;
      busy_q       <= busy_d;
    end
  end

  assign s_ready    = s_ready_q;
  assign m_valid    = head_valid_q;
  assign m_data     = head_data_q;
  assign m_last     = head_last_q & head_valid_q;
  assign burst_done = burst_done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_ibuf_shuffle_stream.sv
// Testbench for ibuf_shuffle_stream: directed burst scenarios plus a random
// valid/ready soak, checked by a scoreboard fed from a behavioural model.
module tb_ibuf_shuffle_stream;

  localparam int BW = 512;
  localparam int NB = 8;
  localparam int RT = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    cfg_mode;
  logic [7:0]    cfg_burst_len;
  logic          s_valid;
  logic          s_ready;
  logic [BW-1:0] s_data;
  logic          m_valid;
  logic          m_ready;
  logic [BW-1:0] m_data;
  logic          m_last;
  logic          burst_done;
  logic          busy;

  ibuf_shuffle_stream dut (
    .clk(clk), .reset(reset), .cfg_mode(cfg_mode), .cfg_burst_len(cfg_burst_len),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .burst_done(burst_done), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic [BW-1:0] d; logic l; } exp_t;
  exp_t exp_q[$];
  exp_t push_e, pop_e;

  int  tests = 0;
  int  fails = 0;
  int  rem = 0;
  int  mdl_mode = 0;
  bit  acc_flag = 1'b0;
  bit  done_pending = 1'b0;
  int  stall = 0;
  int  mr_prob = 100;
  bit  rand_cfg = 1'b0;
  int  dones_seen = 0;
  int  lasts_popped = 0;
  logic [BW-1:0] t1_in, t1_out;

  // Reference transform: output byte p is taken from a source byte index.
  function automatic logic [BW-1:0] ref_xform(input logic [BW-1:0] x, input int mode);
    logic [BW-1:0] y;
    int src;
    for (int p = 0; p < NB*RT; p++) begin
      if (mode == 1)      src = (p % RT) * NB + (p / RT);
      else if (mode == 2) src = (p % NB) * RT + (p / NB);
      else                src = p;
      y[p*8 +: 8] = x[src*8 +: 8];
    end
    return y;
  endfunction

  task automatic chk(input string nm, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Model side: every accepted beat produces an expected output entry.
  always @(negedge clk) begin
    if (reset) begin
      acc_flag = 1'b0;
    end else begin
      acc_flag = s_valid && s_ready;
      if (acc_flag) begin
        if (rem == 0) begin
          mdl_mode = int'(cfg_mode);
          rem = int'(cfg_burst_len) + 1;
        end
        rem--;
        push_e.d = ref_xform(s_data, mdl_mode);
        push_e.l = (rem == 0);
        exp_q.push_back(push_e);
      end
    end
  end

  // Monitor: compare every output handshake and the burst_done pulse.
  always @(negedge clk) begin
    if (reset) begin
      done_pending = 1'b0;
      stall = 0;
    end else begin
      chk("burst_done", burst_done, done_pending);
      if (burst_done) dones_seen++;
      done_pending = 1'b0;
      if (m_valid && m_ready) begin
        stall = 0;
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_beat: got %0h expected no beat", m_data);
        end else begin
          pop_e = exp_q.pop_front();
          chk("m_data", m_data, pop_e.d);
          chk("m_last", m_last, pop_e.l);
          if (pop_e.l) lasts_popped++;
        end
        done_pending = m_last;
      end else if (exp_q.size() > 0) begin
        stall++;
        if (stall > 300) begin
          tests++; fails++;
          $display("FAIL output_stall: got no beat for 300 cycles expected %0d pending", exp_q.size());
          exp_q.delete();
          stall = 0;
        end
      end
    end
  end

  // Downstream ready generator.
  always @(posedge clk) begin
    #2;
    m_ready = ($urandom_range(0, 99) < mr_prob);
  end

  task automatic rand_data();
    for (int w = 0; w < BW/32; w++) s_data[w*32 +: 32] = $urandom();
  endtask

  // Offer beats until n have been accepted.
  task automatic run_beats(input int n, input int pv);
    int got, cyc, lim;
    bit done;
    got = 0; cyc = 0; lim = n*40 + 200; done = 1'b0;
    while (!done) begin
      @(posedge clk); #2;
      if (acc_flag) got++;
      if (got >= n) begin
        s_valid = 1'b0;
        done = 1'b1;
      end else if (cyc >= lim) begin
        s_valid = 1'b0;
        tests++; fails++;
        $display("FAIL run_beats_timeout: got %0d accepted expected %0d", got, n);
        done = 1'b1;
      end else if (!s_valid || acc_flag) begin
        s_valid = ($urandom_range(0, 99) < pv);
        rand_data();
        if (rand_cfg) begin
          cfg_mode = 2'($urandom_range(0, 3));
          cfg_burst_len = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 40))
                                                       : 8'($urandom_range(0, 4));
        end
      end
      cyc++;
    end
  endtask

  task automatic drain();
    int c;
    c = 0;
    while (exp_q.size() > 0 && c < 1000) begin
      @(negedge clk);
      c++;
    end
    if (c >= 1000) begin
      tests++; fails++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    exp_q.delete();
    rem = 0;
  endtask

  initial begin
    #600000;
    tests++; fails++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    s_valid = 1'b0; s_data = '0; cfg_mode = 2'd0; cfg_burst_len = 8'd0; m_ready = 1'b1;
    apply_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_s_ready", s_ready, 1'b1);
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_m_last", m_last, 1'b0);
    chk("rst_burst_done", burst_done, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_m_data", m_data, '0);
    @(posedge clk); #2;
    reset = 1'b0;

    // T1: single-beat shuffle of bytes 0..63.
    @(posedge clk); #2;
    for (int k = 0; k < 64; k++) t1_in[k*8 +: 8] = 8'(k);
    s_data = t1_in; cfg_mode = 2'd1; cfg_burst_len = 8'd0; s_valid = 1'b1;
    @(negedge clk);
    chk("t1_s_ready", s_ready, 1'b1);
    @(posedge clk); #2;
    s_valid = 1'b0;
    @(negedge clk);
    chk("t1_m_valid", m_valid, 1'b1);
    chk("t1_m_last", m_last, 1'b1);
    chk("t1_byte0", m_data[7:0], 8'd0);
    chk("t1_byte1", m_data[15:8], 8'd8);
    chk("t1_byte7", m_data[63:56], 8'd56);
    chk("t1_byte8", m_data[71:64], 8'd1);
    chk("t1_byte63", m_data[511:504], 8'd63);
    t1_out = m_data;
    @(negedge clk);
    chk("t1_done_pulse", burst_done, 1'b1);
    @(negedge clk);
    chk("t1_done_clear", burst_done, 1'b0);

    // T2: unshuffle restores the original beat; bypass passes through.
    @(posedge clk); #2;
    s_data = t1_out; cfg_mode = 2'd2; s_valid = 1'b1;
    @(posedge clk); #2;
    s_valid = 1'b0;
    @(negedge clk);
    chk("t2_roundtrip", m_data, t1_in);
    cfg_mode = 2'd0; cfg_burst_len = 8'd2;
    run_beats(3, 100);
    drain();

    // T3: backpressure with a 4-beat shuffle burst.
    mr_prob = 0;
    @(posedge clk);
    cfg_mode = 2'd1; cfg_burst_len = 8'd3;
    run_beats(2, 100);
    @(negedge clk);
    chk("t3_full_s_ready", s_ready, 1'b0);
    chk("t3_full_busy", busy, 1'b1);
    chk("t3_full_m_valid", m_valid, 1'b1);
    repeat (2) @(negedge clk);
    chk("t3_still_full", s_ready, 1'b0);
    mr_prob = 100;
    run_beats(2, 100);
    drain();
    chk("t3_idle_busy", busy, 1'b0);

    // T4: config changes mid-burst are ignored until the next burst.
    cfg_mode = 2'd1; cfg_burst_len = 8'd3;
    run_beats(1, 100);
    cfg_mode = 2'd2; cfg_burst_len = 8'd0;
    run_beats(3, 100);
    run_beats(1, 100);
    drain();

    // T5: reset in the middle of a burst.
    mr_prob = 0;
    @(posedge clk);
    cfg_mode = 2'd1; cfg_burst_len = 8'd5;
    run_beats(2, 100);
    #1;
    apply_reset();
    #1;
    chk("t5_m_valid", m_valid, 1'b0);
    chk("t5_s_ready", s_ready, 1'b1);
    chk("t5_busy", busy, 1'b0);
    chk("t5_m_last", m_last, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    mr_prob = 100;
    cfg_mode = 2'd0; cfg_burst_len = 8'd0;
    run_beats(1, 100);
    @(negedge clk);
    chk("t5_new_last", m_last, 1'b1);
    drain();

    // T6: random soak.
    dones_seen = 0; lasts_popped = 0;
    rand_cfg = 1'b1; mr_prob = 50;
    run_beats(1000, 50);
    mr_prob = 100;
    drain();
    chk("t6_burst_done_count", dones_seen, lasts_popped);
    chk("t6_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
